// File: rtl/obj_dma_ctrl.sv
// Vertical-blank copy of CPU sprite RAM into object attribute RAM (8257 channel replacement).
// Arms on a trigger pulse, takes the Z80 bus via BUSRQ/BUSACK, copies LEN bytes, releases.
module obj_dma_ctrl #(
  parameter logic [15:0] SRC_BASE = 16'h6900,
  parameter int          LEN      = 384,
  parameter int          DST_AW   = 9
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              dma_start,
  input  logic              vblk,
  output logic              busreq_n,
  input  logic              busack_n,
  output logic [15:0]       src_addr,
  output logic              src_rd,
  input  logic [7:0]        src_data,
  output logic [DST_AW-1:0] dst_addr,
  output logic              dst_wr,
  output logic [7:0]        dst_data,
  output logic              dma_busy,
  output logic              dma_done
);

  typedef enum logic [2:0] {IDLE, WAIT_VB, REQ, READ, WRITE, RELEASE} state_t;

  localparam logic [9:0] LAST = 10'(LEN - 1);

  generate
    if (LEN < 1 || LEN > 512) begin : g_len_chk
      $error("obj_dma_ctrl: LEN must be within 1..512");
    end
  endgenerate

  state_t            state, next;
  logic              pending;
  logic [9:0]        n;
  logic [15:0]       src_q;
  logic [DST_AW-1:0] dst_q;
  logic              armed;

  assign armed = pending | dma_start;

  // A start landing on the cycle REQ is entered is absorbed by that transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= 1'b0;
      n       <= '0;
      src_q   <= SRC_BASE;
      dst_q   <= '0;
    end else begin
      state <= next;
      if (next == REQ && state != REQ) pending <= 1'b0;
      else if (dma_start)              pending <= 1'b1;
      if (state == REQ && !busack_n) begin
        n     <= '0;
        src_q <= SRC_BASE;
        dst_q <= '0;
      end else if (state == WRITE && !busack_n && n != LAST) begin
        n     <= n + 10'd1;
        src_q <= src_q + 16'd1;
        dst_q <= dst_q + DST_AW'(1);
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (armed) next = vblk ? REQ : WAIT_VB;
      WAIT_VB: if (vblk) next = REQ;
      REQ:     if (!busack_n) next = READ;
      READ:    if (!busack_n) next = WRITE;
      // A lost bus during WRITE means the read data is stale: go back and re-read.
      WRITE:   if (busack_n) next = READ;
               else if (n == LAST) next = RELEASE;
               else next = READ;
      RELEASE: next = IDLE;
      default: next = IDLE;
    endcase
  end

  always_comb begin
    busreq_n = 1'b1;
    dma_busy = 1'b0;
    dma_done = 1'b0;
    src_rd   = 1'b0;
    dst_wr   = 1'b0;
    dst_data = 8'h00;
    case (state)
      REQ: begin
        busreq_n = 1'b0;
        dma_busy = 1'b1;
      end
      READ: begin
        busreq_n = 1'b0;
        dma_busy = 1'b1;
        src_rd   = !busack_n;
      end
      WRITE: begin
        busreq_n = 1'b0;
        dma_busy = 1'b1;
        dst_wr   = !busack_n;
        dst_data = src_data;
      end
      RELEASE: dma_done = 1'b1;
      default: ;
    endcase
  end

  assign src_addr = src_q;
  assign dst_addr = dst_q;

endmodule
